// File: rtl/led_matrix_scanner_if.sv
// Pin bundle between a pattern generator (master) and the LED matrix scanner (slave).
// Carries the back-buffer write port, the commit handshake and the row/column drive.
interface led_matrix_scanner_if;
  logic       en;
  logic       wr_en;
  logic [2:0] wr_row;
  logic [6:0] wr_data;
  logic       commit;
  logic       swap_pending;
  logic       frame_tick;
  logic [4:0] row;
  logic [6:0] column;

  modport master (
    output en, wr_en, wr_row, wr_data, commit,
    input  swap_pending, frame_tick, row, column
  );

  modport slave (
    input  en, wr_en, wr_row, wr_data, commit,
    output swap_pending, frame_tick, row, column
  );
endinterface

// File: rtl/led_matrix_scanner.sv
// Row-at-a-time scanner for a 5x7 LED dot matrix with a double-buffered frame.
// Each row is preceded by an all-off blanking gap; the front buffer only changes at frame edges.
module led_matrix_scanner #(
  parameter int DWELL_CYCLES = 10000,
  parameter int BLANK_CYCLES = 100
) (
  input  logic                 clk,
  input  logic                 rst_n,
  led_matrix_scanner_if.slave  bus
);
  localparam int MAX_CYCLES = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int CW = $clog2(MAX_CYCLES + 1);
  localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL_CYCLES - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [2:0]    LAST_ROW   = 3'd4;

  typedef enum logic [1:0] {IDLE, BLANK, DRIVE} state_t;

  state_t        state_q, state_d;
  logic [2:0]    r_q, r_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          frame_edge;
  logic          do_swap;

  logic [6:0] back_q  [5];
  logic [6:0] back_d  [5];
  logic [6:0] front_q [5];
  logic [6:0] front_d [5];

  logic       swap_pending_q, swap_pending_d;
  logic       frame_tick_q, frame_tick_d;
  logic [4:0] row_q, row_d;
  logic [6:0] column_q, column_d;

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      r_q            <= '0;
      cnt_q          <= '0;
      swap_pending_q <= 1'b0;
      frame_tick_q   <= 1'b0;
      row_q          <= '0;
      column_q       <= '0;
      for (int i = 0; i < 5; i++) begin
        back_q[i]  <= '0;
        front_q[i] <= '0;
      end
    end else begin
      state_q        <= state_d;
      r_q            <= r_d;
      cnt_q          <= cnt_d;
      swap_pending_q <= swap_pending_d;
      frame_tick_q   <= frame_tick_d;
      row_q          <= row_d;
      column_q       <= column_d;
      for (int i = 0; i < 5; i++) begin
        back_q[i]  <= back_d[i];
        front_q[i] <= front_d[i];
      end
    end
  end

  // Next-state logic; frame_edge marks every transition into row 0 BLANK
  always_comb begin
    state_d    = state_q;
    r_d        = r_q;
    cnt_d      = cnt_q;
    frame_edge = 1'b0;
    if (!bus.en) begin
      state_d = IDLE;
      r_d     = '0;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d    = BLANK;
          r_d        = '0;
          cnt_d      = '0;
          frame_edge = 1'b1;
        end
        BLANK: begin
          if (cnt_q == BLANK_LAST) begin
            state_d = DRIVE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        DRIVE: begin
          if (cnt_q == DWELL_LAST) begin
            state_d = BLANK;
            cnt_d   = '0;
            if (r_q == LAST_ROW) begin
              r_d        = '0;
              frame_edge = 1'b1;
            end else begin
              r_d = r_q + 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
          r_d     = '0;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Outputs are computed from the next state so the registered pins line up with state_q
  always_comb begin
    do_swap        = frame_edge && (swap_pending_q || bus.commit);
    swap_pending_d = swap_pending_q;
    if (do_swap) begin
      swap_pending_d = 1'b0;
    end else if (bus.commit) begin
      swap_pending_d = 1'b1;
    end
    // The copy reads back_q, so a write landing on the same edge misses this frame
    for (int i = 0; i < 5; i++) begin
      back_d[i]  = back_q[i];
      front_d[i] = do_swap ? back_q[i] : front_q[i];
      if (bus.wr_en && (bus.wr_row == i[2:0])) begin
        back_d[i] = bus.wr_data;
      end
    end
    frame_tick_d = frame_edge;
    row_d        = '0;
    column_d     = '0;
    if (state_d == DRIVE) begin
      row_d    = 5'b00001 << r_d;
      column_d = front_q[r_d];
    end
  end

  assign bus.swap_pending = swap_pending_q;
  assign bus.frame_tick   = frame_tick_q;
  assign bus.row          = row_q;
  assign bus.column       = column_q;
endmodule

// File: tb/tb_led_matrix_scanner.sv
// Directed bench for led_matrix_scanner with DWELL=4, BLANK=2 (frame period 30 clocks).
// Frame contents are supplied by each test as hand-computed 35-bit patterns (row r at bits 7r+:7).
module tb_led_matrix_scanner;
  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  led_matrix_scanner_if bus ();

  led_matrix_scanner #(
    .DWELL_CYCLES(4),
    .BLANK_CYCLES(2)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic write_row(input logic [2:0] r, input logic [6:0] d);
    bus.wr_en   = 1'b1;
    bus.wr_row  = r;
    bus.wr_data = d;
    tick();
    bus.wr_en = 1'b0;
    $display("write row=%0d data=0x%02h", r, d);
  endtask

  task automatic pulse_commit();
    bus.commit = 1'b1;
    tick();
    bus.commit = 1'b0;
    $display("commit pending=%0b", bus.swap_pending);
  endtask

  // Checks one full frame starting at its frame_tick cycle; optionally applies one
  // write/commit at frame index act_idx (takes effect on the following edge).
  task automatic run_frame(input string name, input logic [34:0] exp_frame, input int act_idx,
                           input logic [2:0] a_row, input logic [6:0] a_data, input logic a_commit);
    int   ph;
    int   r;
    logic [4:0] exp_row;
    logic [6:0] exp_col;
    for (int i = 0; i < 30; i++) begin
      ph = i % 6;
      r  = i / 6;
      exp_row = (ph < 2) ? 5'd0 : (5'd1 << r);
      exp_col = (ph < 2) ? 7'd0 : exp_frame[7*r +: 7];
      check($sformatf("%s i=%0d row", name, i), 32'(bus.row), 32'(exp_row));
      check($sformatf("%s i=%0d column", name, i), 32'(bus.column), 32'(exp_col));
      check($sformatf("%s i=%0d frame_tick", name, i), 32'(bus.frame_tick), 32'(i == 0));
      check($sformatf("%s i=%0d swap_pending", name, i), 32'(bus.swap_pending),
            32'(a_commit && (i > act_idx)));
      if (i == act_idx) begin
        bus.wr_en   = 1'b1;
        bus.wr_row  = a_row;
        bus.wr_data = a_data;
        bus.commit  = a_commit;
        tick();
        bus.wr_en  = 1'b0;
        bus.commit = 1'b0;
      end else begin
        tick();
      end
    end
    $display("frame %s done, checks=%0d errors=%0d", name, checks, errors);
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    rst_n       = 1'b0;
    bus.en      = 1'b1;
    bus.wr_en   = 1'b1;
    bus.wr_row  = 3'd0;
    bus.wr_data = 7'h7F;
    bus.commit  = 1'b0;

    // Reset held with en and a write active: everything stays dark and empty
    for (int i = 0; i < 3; i++) begin
      tick();
      check("reset row", 32'(bus.row), 32'd0);
      check("reset column", 32'(bus.column), 32'd0);
      check("reset swap_pending", 32'(bus.swap_pending), 32'd0);
      check("reset frame_tick", 32'(bus.frame_tick), 32'd0);
    end
    bus.wr_en = 1'b0;
    rst_n     = 1'b1;
    tick();
    run_frame("empty", 35'd0, -1, 3'd0, 7'd0, 1'b0);

    // Load row 2 while idle, commit, then enable
    bus.en = 1'b0;
    tick();
    check("idle row", 32'(bus.row), 32'd0);
    check("idle column", 32'(bus.column), 32'd0);
    write_row(3'd2, 7'b1010101);
    pulse_commit();
    check("idle pending", 32'(bus.swap_pending), 32'd1);
    bus.en = 1'b1;
    tick();
    run_frame("row2", 35'h55 << 14, -1, 3'd0, 7'd0, 1'b0);

    // Mid-frame write+commit during row 1 DRIVE: shows only from the next frame
    run_frame("midcommit", 35'h55 << 14, 9, 3'd0, 7'h7F, 1'b1);
    run_frame("row0row2", (35'h55 << 14) | 35'h7F, -1, 3'd0, 7'd0, 1'b0);

    // Drop enable during row 3 DRIVE
    for (int i = 0; i < 21; i++) tick();
    check("row3 before drop", 32'(bus.row), 32'b01000);
    bus.en = 1'b0;
    tick();
    check("drop row", 32'(bus.row), 32'd0);
    check("drop column", 32'(bus.column), 32'd0);
    tick();
    check("dropped row", 32'(bus.row), 32'd0);

    // Out-of-range writes plus commit leave the front buffer untouched
    write_row(3'd5, 7'h01);
    write_row(3'd6, 7'h02);
    write_row(3'd7, 7'h04);
    pulse_commit();
    check("oob pending", 32'(bus.swap_pending), 32'd1);
    bus.en = 1'b1;
    tick();
    run_frame("oob", (35'h55 << 14) | 35'h7F, -1, 3'd0, 7'd0, 1'b0);

    // Write on the final row 4 DRIVE cycle with commit: copy happens without that write
    run_frame("stage1", (35'h55 << 14) | 35'h7F, 5, 3'd1, 7'h22, 1'b0);
    run_frame("lastcyc", (35'h55 << 14) | 35'h7F, 29, 3'd4, 7'h11, 1'b1);
    run_frame("postlast", (35'h55 << 14) | (35'h22 << 7) | 35'h7F, 0, 3'd7, 7'h00, 1'b1);
    run_frame("final", (35'h11 << 28) | (35'h55 << 14) | (35'h22 << 7) | 35'h7F,
              -1, 3'd0, 7'd0, 1'b0);

    // Reset mid-frame with a commit pending
    for (int i = 0; i < 10; i++) tick();
    pulse_commit();
    check("pre-reset pending", 32'(bus.swap_pending), 32'd1);
    rst_n = 1'b0;
    tick();
    check("midreset row", 32'(bus.row), 32'd0);
    check("midreset column", 32'(bus.column), 32'd0);
    check("midreset pending", 32'(bus.swap_pending), 32'd0);
    rst_n = 1'b1;
    tick();
    run_frame("after reset", 35'd0, -1, 3'd0, 7'd0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
